// File: rtl/aes_keyram_pkg.sv
// Shared types and geometry helpers for the multi-context AES round-key store.
package aes_keyram_pkg;

    localparam int unsigned MAX_ROUNDS = 14;

    typedef enum logic [1:0] {
        MODE_AES128  = 2'd0,
        MODE_AES192  = 2'd1,
        MODE_AES256  = 2'd2,
        MODE_ILLEGAL = 2'd3
    } key_mode_e;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_LOAD = 1'b1
    } ld_state_e;

    // Number of cipher rounds for a key mode.
    function automatic int unsigned nr_of(input key_mode_e mode);
        case (mode)
            MODE_AES128: return 10;
            MODE_AES192: return 12;
            default:     return 14;
        endcase
    endfunction

    function automatic int unsigned wpr_of(input int unsigned word_w);
        return 128 / word_w;
    endfunction

    function automatic int unsigned wps_of(input int unsigned word_w);
        return (MAX_ROUNDS + 1) * wpr_of(word_w);
    endfunction

endpackage

// File: rtl/aes_keyram_ctx_if.sv
// Load, invalidate and read bus between key expansion, round pipeline and key store.
interface aes_keyram_ctx_if #(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned N_CTX  = 4
);
    import aes_keyram_pkg::*;

    localparam int unsigned CTX_W  = (N_CTX > 1) ? $clog2(N_CTX) : 1;
    localparam int unsigned WSEL_W = (wpr_of(WORD_W) > 1) ? $clog2(wpr_of(WORD_W)) : 1;

    logic              load_start;
    logic [CTX_W-1:0]  load_ctx;
    logic [1:0]        load_mode;
    logic              load_valid;
    logic              load_ready;
    logic [WORD_W-1:0] load_data;
    logic              load_busy;
    logic              load_err;
    logic              inv_req;
    logic [CTX_W-1:0]  inv_ctx;
    logic              rd_req;
    logic [CTX_W-1:0]  rd_ctx;
    logic [3:0]        rd_round;
    logic [WSEL_W-1:0] rd_word;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              rd_last;
    logic [N_CTX-1:0]  slot_valid;

    modport master (
        output load_start, load_ctx, load_mode, load_valid, load_data,
        output inv_req, inv_ctx, rd_req, rd_ctx, rd_round, rd_word,
        input  load_ready, load_busy, load_err,
        input  rd_data, rd_valid, rd_err, rd_last, slot_valid
    );

    modport slave (
        input  load_start, load_ctx, load_mode, load_valid, load_data,
        input  inv_req, inv_ctx, rd_req, rd_ctx, rd_round, rd_word,
        output load_ready, load_busy, load_err,
        output rd_data, rd_valid, rd_err, rd_last, slot_valid
    );

endinterface

// File: rtl/aes_keyram_dpram.sv
// Simple dual-port RAM, read-first, registered read port with synchronous zero-load.
module aes_keyram_dpram #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned DEPTH  = 120,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic              rclr,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register only; rclr forces zero for errored requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= rclr ? '0 : mem[raddr];
    end

endmodule

// File: rtl/aes_keyram_ctx.sv
// Multi-context AES round-key store: streaming loader, slot flags and checked 1-cycle reads.
module aes_keyram_ctx
    import aes_keyram_pkg::*;
#(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned N_CTX  = 4
) (
    input logic              clk,
    input logic              kill_n,
    aes_keyram_ctx_if.slave  bus
);

    localparam int unsigned WPR    = wpr_of(WORD_W);
    localparam int unsigned WPS    = wps_of(WORD_W);
    localparam int unsigned DEPTH  = N_CTX * WPS;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CTX_W  = (N_CTX > 1) ? $clog2(N_CTX) : 1;
    localparam int unsigned WSEL_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int unsigned CNT_W  = $clog2(WPS + 1);

    ld_state_e          state;
    logic [CTX_W-1:0]   ld_ctx;
    key_mode_e          ld_mode;
    logic [CNT_W-1:0]   ld_cnt;
    key_mode_e          slot_mode [N_CTX];
    logic [N_CTX-1:0]   slot_valid_q;
    logic               load_ready_q;
    logic               load_busy_q;
    logic               load_err_q;
    logic               rd_valid_q;
    logic               rd_err_q;
    logic               rd_last_q;

    logic               mode_legal_c;
    logic [CNT_W-1:0]   last_cnt_c;
    logic               wr_en_c;
    logic [ADDR_W-1:0]  wr_addr_c;
    logic [WSEL_W-1:0]  word_sel_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic               rd_err_c;
    logic               rd_last_c;

    always_comb begin
        mode_legal_c = (key_mode_e'(bus.load_mode) != MODE_ILLEGAL);
        last_cnt_c   = CNT_W'((nr_of(ld_mode) + 1) * WPR - 1);
        wr_en_c      = (state == LD_LOAD) && bus.load_valid;
        wr_addr_c    = ADDR_W'(ld_ctx) * ADDR_W'(WPS) + ADDR_W'(ld_cnt);
        // rd_word has no meaning when a round key is a single word
        word_sel_c   = bus.rd_word & WSEL_W'(WPR - 1);
        rd_addr_c    = ADDR_W'(bus.rd_ctx) * ADDR_W'(WPS)
                     + ADDR_W'(bus.rd_round) * ADDR_W'(WPR) + ADDR_W'(word_sel_c);
        rd_err_c     = !slot_valid_q[bus.rd_ctx]
                     || (32'(bus.rd_round) > nr_of(slot_mode[bus.rd_ctx]));
        rd_last_c    = !rd_err_c
                     && (32'(bus.rd_round) == nr_of(slot_mode[bus.rd_ctx]))
                     && (word_sel_c == WSEL_W'(WPR - 1));
    end

    // Load FSM and slot flags; later assignments to slot_valid_q take priority.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state        <= LD_IDLE;
            ld_ctx       <= '0;
            ld_mode      <= MODE_AES128;
            ld_cnt       <= '0;
            slot_valid_q <= '0;
            load_ready_q <= 1'b0;
            load_busy_q  <= 1'b0;
            load_err_q   <= 1'b0;
            for (int i = 0; i < N_CTX; i++) slot_mode[i] <= MODE_AES128;
        end else begin
            load_err_q <= 1'b0;
            case (state)
                LD_IDLE: begin
                    if (bus.load_start) begin
                        if (mode_legal_c) begin
                            state        <= LD_LOAD;
                            ld_ctx       <= bus.load_ctx;
                            ld_mode      <= key_mode_e'(bus.load_mode);
                            ld_cnt       <= '0;
                            load_ready_q <= 1'b1;
                            load_busy_q  <= 1'b1;
                        end else begin
                            load_err_q   <= 1'b1;
                        end
                    end
                end
                LD_LOAD: begin
                    if (bus.load_start) load_err_q <= 1'b1;
                    if (bus.load_valid) begin
                        ld_cnt <= ld_cnt + CNT_W'(1);
                        if (ld_cnt == last_cnt_c) begin
                            state                <= LD_IDLE;
                            load_ready_q         <= 1'b0;
                            load_busy_q          <= 1'b0;
                            slot_valid_q[ld_ctx] <= 1'b1;
                            slot_mode[ld_ctx]    <= ld_mode;
                        end
                    end
                    if (bus.inv_req && (bus.inv_ctx == ld_ctx)) begin
                        state        <= LD_IDLE;
                        load_ready_q <= 1'b0;
                        load_busy_q  <= 1'b0;
                    end
                end
                default: state <= LD_IDLE;
            endcase
            if (bus.inv_req) slot_valid_q[bus.inv_ctx] <= 1'b0;
            if ((state == LD_IDLE) && bus.load_start && mode_legal_c)
                slot_valid_q[bus.load_ctx] <= 1'b0;
        end
    end

    // Read status; err/last hold alongside the held data between requests.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                rd_err_q  <= rd_err_c;
                rd_last_q <= rd_last_c;
            end
        end
    end

    aes_keyram_dpram #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (kill_n),
        .we    (wr_en_c),
        .waddr (wr_addr_c),
        .wdata (bus.load_data),
        .re    (bus.rd_req),
        .rclr  (rd_err_c),
        .raddr (rd_addr_c),
        .rdata (bus.rd_data)
    );

    assign bus.slot_valid = slot_valid_q;
    assign bus.load_ready = load_ready_q;
    assign bus.load_busy  = load_busy_q;
    assign bus.load_err   = load_err_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.rd_last    = rd_last_q;

endmodule

// File: tb/tb_aes_keyram_ctx.sv
// Directed bench for aes_keyram_ctx with FIPS-197 AES-128 round keys (WORD_W=64, N_CTX=4).
module tb_aes_keyram_ctx;

    logic clk;
    logic kill_n;
    int   n_checks;
    int   n_errors;
    logic [127:0] rk [11];

    aes_keyram_ctx_if #(.WORD_W(64), .N_CTX(4)) bus ();

    aes_keyram_ctx #(.WORD_W(64), .N_CTX(4)) dut (
        .clk    (clk),
        .kill_n (kill_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Round key bytes in FIPS order; word w holds bytes 8w..8w+7, first byte in bits 7:0.
    function automatic logic [63:0] rk_word(input int r, input int w);
        logic [127:0] k;
        logic [63:0]  res;
        k = rk[r];
        for (int b = 0; b < 8; b++) res[8*b +: 8] = k[127 - 8*(8*w + b) -: 8];
        return res;
    endfunction

    function automatic logic [63:0] pat(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int ctx, input int mode);
        bus.load_start = 1'b1;
        bus.load_ctx   = 2'(ctx);
        bus.load_mode  = 2'(mode);
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic load_word(input logic [63:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic load_fips128(input int ctx);
        start_load(ctx, 0);
        for (int i = 0; i < 22; i++) load_word(rk_word(i / 2, i % 2));
    endtask

    task automatic read_chk(input string tag, input int ctx, input int rnd, input int wd,
                            input logic [63:0] exp_data, input logic exp_err, input logic exp_last);
        bus.rd_req   = 1'b1;
        bus.rd_ctx   = 2'(ctx);
        bus.rd_round = 4'(rnd);
        bus.rd_word  = 1'(wd);
        tick();
        bus.rd_req   = 1'b0;
        check_eq({tag, "_valid"}, 64'(bus.rd_valid), 64'(1));
        check_eq({tag, "_data"},  bus.rd_data, exp_data);
        check_eq({tag, "_err"},   64'(bus.rd_err), 64'(exp_err));
        check_eq({tag, "_last"},  64'(bus.rd_last), 64'(exp_last));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_slot_valid"}, 64'(bus.slot_valid), 64'(0));
        check_eq({tag, "_rd_valid"},   64'(bus.rd_valid), 64'(0));
        check_eq({tag, "_rd_data"},    bus.rd_data, 64'(0));
        check_eq({tag, "_rd_err"},     64'(bus.rd_err), 64'(0));
        check_eq({tag, "_rd_last"},    64'(bus.rd_last), 64'(0));
        check_eq({tag, "_load_ready"}, 64'(bus.load_ready), 64'(0));
        check_eq({tag, "_load_busy"},  64'(bus.load_busy), 64'(0));
        check_eq({tag, "_load_err"},   64'(bus.load_err), 64'(0));
    endtask

    initial begin
        logic [63:0] held;
        n_checks = 0;
        n_errors = 0;
        rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        kill_n         = 1'b0;
        bus.load_start = 1'b0;
        bus.load_ctx   = '0;
        bus.load_mode  = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.inv_req    = 1'b0;
        bus.inv_ctx    = '0;
        bus.rd_req     = 1'b0;
        bus.rd_ctx     = '0;
        bus.rd_round   = '0;
        bus.rd_word    = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        kill_n = 1'b1;
        tick();

        // AES-128 FIPS key into ctx 2
        start_load(2, 0);
        check_eq("ld2_busy",  64'(bus.load_busy), 64'(1));
        check_eq("ld2_ready", 64'(bus.load_ready), 64'(1));
        for (int i = 0; i < 22; i++) load_word(rk_word(i / 2, i % 2));
        check_eq("ld2_slot_valid", 64'(bus.slot_valid), 64'h4);
        check_eq("ld2_idle", 64'(bus.load_busy), 64'(0));

        read_chk("r0w0",  2, 0, 0, 64'h0706050403020100, 1'b0, 1'b0);
        read_chk("r0w1",  2, 0, 1, 64'h0f0e0d0c0b0a0908, 1'b0, 1'b0);
        read_chk("r10w0", 2, 10, 0, 64'h174a94e37f1d1113, 1'b0, 1'b0);
        read_chk("r10w1", 2, 10, 1, 64'hc5302b4d8ba707f3, 1'b0, 1'b1);
        read_chk("r5w1",  2, 5, 1, rk_word(5, 1), 1'b0, 1'b0);
        read_chk("r11",   2, 11, 0, 64'h0, 1'b1, 1'b0);
        read_chk("ctx1",  1, 0, 0, 64'h0, 1'b1, 1'b0);
        read_chk("r1w0",  2, 1, 0, rk_word(1, 0), 1'b0, 1'b0);
        held = rk_word(1, 0);
        tick();
        check_eq("idle_rd_valid", 64'(bus.rd_valid), 64'(0));
        check_eq("idle_rd_held",  bus.rd_data, held);

        // illegal mode
        start_load(1, 3);
        check_eq("ill_err",  64'(bus.load_err), 64'(1));
        check_eq("ill_busy", 64'(bus.load_busy), 64'(0));
        check_eq("ill_slot", 64'(bus.slot_valid), 64'h4);
        tick();
        check_eq("ill_err_pulse", 64'(bus.load_err), 64'(0));

        // AES-256 into ctx 0 at half rate, reads of ctx 2 every cycle
        start_load(0, 2);
        for (int k = 0; k < 59; k++) begin
            bus.load_valid = (k % 2 == 0);
            bus.load_data  = pat(k / 2);
            bus.load_start = (k == 5);
            bus.load_ctx   = 2'd3;
            bus.load_mode  = 2'd0;
            bus.rd_req     = 1'b1;
            bus.rd_ctx     = 2'd2;
            bus.rd_round   = 4'((k / 2) % 11);
            bus.rd_word    = 1'(k % 2);
            tick();
            check_eq("ilv_data", bus.rd_data, rk_word((k / 2) % 11, k % 2));
            check_eq("ilv_err",  64'(bus.rd_err), 64'(0));
            if (k == 5) begin
                check_eq("busy_start_err",  64'(bus.load_err), 64'(1));
                check_eq("busy_start_busy", 64'(bus.load_busy), 64'(1));
            end
            if (k == 57) check_eq("slot0_early", 64'(bus.slot_valid[0]), 64'(0));
        end
        bus.load_valid = 1'b0;
        bus.load_start = 1'b0;
        bus.rd_req     = 1'b0;
        check_eq("ld0_slot_valid", 64'(bus.slot_valid), 64'h5);
        check_eq("ld0_idle", 64'(bus.load_busy), 64'(0));
        read_chk("c0r14w1", 0, 14, 1, pat(29), 1'b0, 1'b1);
        read_chk("c0r0w0",  0, 0, 0, pat(0), 1'b0, 1'b0);
        read_chk("c0r15",   0, 15, 0, 64'h0, 1'b1, 1'b0);

        // invalidate ctx 0 at word 10 of a reload
        start_load(0, 2);
        check_eq("reld0_cleared", 64'(bus.slot_valid), 64'h4);
        for (int i = 0; i < 10; i++) load_word(pat(100 + i));
        bus.load_valid = 1'b1;
        bus.load_data  = pat(110);
        bus.inv_req    = 1'b1;
        bus.inv_ctx    = 2'd0;
        tick();
        bus.load_valid = 1'b0;
        bus.inv_req    = 1'b0;
        check_eq("inv_busy",  64'(bus.load_busy), 64'(0));
        check_eq("inv_ready", 64'(bus.load_ready), 64'(0));
        check_eq("inv_slot",  64'(bus.slot_valid), 64'h4);
        read_chk("inv_rd", 0, 0, 0, 64'h0, 1'b1, 1'b0);

        // kill mid-load of ctx 3 with a valid ctx 2 read in flight
        start_load(3, 0);
        for (int i = 0; i < 5; i++) load_word(pat(200 + i));
        read_chk("prekill", 2, 0, 1, 64'h0f0e0d0c0b0a0908, 1'b0, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_data  = pat(205);
        #2;
        kill_n = 1'b0;
        bus.load_valid = 1'b0;
        #1;
        check_reset_outputs("kill");
        tick();
        kill_n = 1'b1;
        tick();
        load_fips128(2);
        check_eq("rel_slot_valid", 64'(bus.slot_valid), 64'h4);
        read_chk("rel_r0w0", 2, 0, 0, 64'h0706050403020100, 1'b0, 1'b0);
        read_chk("rel_r0w1", 2, 0, 1, 64'h0f0e0d0c0b0a0908, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
